// File: rtl/wb_arbiter.sv
// wb_arbiter
// Round-robin arbiter sharing one pipelined Wishbone slave port between
// N_MASTERS pipelined masters. The winning master's request is routed to the
// slave combinationally and the slave's responses are routed back to it.
// Accepted-but-unanswered transfers are counted and capped at
// MAX_OUTSTANDING. A watchdog aborts a cycle whose slave stops responding.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i  per-master request controls (one bit per master)
//   m_adr_i/m_dat_i/m_sel_i packed per-master address/data/select, master k in slice k
//   m_dat_o                 slave read data broadcast to all masters
//   m_ack_o/m_err_o         per-master responses, only the owner sees them
//   m_stall_o               per-master stall, non-owners are always stalled
//   s_*_o                   request towards the slave
//   s_dat_i/s_ack_i/s_err_i/s_stall_i  slave responses
//   gnt_o                   registered one-hot owner, zero when idle
//   timeout_o               one-cycle pulse when the watchdog aborts a cycle
module wb_arbiter #(
    parameter int N_MASTERS       = 2,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int SEL_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_MASTERS-1:0]            m_cyc_i,
    input  logic [N_MASTERS-1:0]            m_stb_i,
    input  logic [N_MASTERS-1:0]            m_we_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [N_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    output logic [DATA_WIDTH-1:0]           m_dat_o,
    output logic [N_MASTERS-1:0]            m_ack_o,
    output logic [N_MASTERS-1:0]            m_err_o,
    output logic [N_MASTERS-1:0]            m_stall_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [ADDR_WIDTH-1:0]           s_adr_o,
    output logic [DATA_WIDTH-1:0]           s_dat_o,
    output logic [SEL_WIDTH-1:0]            s_sel_o,
    input  logic [DATA_WIDTH-1:0]           s_dat_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    input  logic                            s_stall_i,
    output logic [N_MASTERS-1:0]            gnt_o,
    output logic                            timeout_o
);

    localparam int IDXW = $clog2(N_MASTERS);
    localparam int CNTW = 4;
    localparam int WDW  = 16;

    typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     g_q, g_d;
    logic [IDXW-1:0]     last_q, last_d;
    logic [CNTW-1:0]     outst_q, outst_d;
    logic [WDW-1:0]      wdog_q, wdog_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic                timeout_q, timeout_d;

    logic                full;
    logic                accept;
    logic                resp;
    logic                dec;
    logic [IDXW-1:0]     pick;
    logic                pick_vld;

    assign full   = (outst_q == CNTW'(MAX_OUTSTANDING));
    assign accept = s_stb_o & ~s_stall_i;
    assign resp   = (state_q == GRANT) & (s_ack_i | s_err_i);
    // A response with nothing outstanding is still forwarded but not counted.
    assign dec    = resp & (outst_q != '0);

    // Round-robin search starting just after the last owner, with wrap.
    always_comb begin
        int j;
        logic [IDXW-1:0] idx;
        j        = 0;
        idx      = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            j = int'(last_q) + i;
            if (j >= N_MASTERS) j = j - N_MASTERS;
            idx = IDXW'(j);
            if (!pick_vld && m_cyc_i[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // Request data path follows the current index; only cyc/stb are gated.
    assign s_we_o  = m_we_i[g_q];
    assign s_adr_o = m_adr_i[int'(g_q)*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_dat_o = m_dat_i[int'(g_q)*DATA_WIDTH +: DATA_WIDTH];
    assign s_sel_o = m_sel_i[int'(g_q)*SEL_WIDTH +: SEL_WIDTH];
    assign m_dat_o = s_dat_i;

    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m_stall_o = '1;
        m_ack_o   = '0;
        m_err_o   = '0;
        case (state_q)
            GRANT: begin
                s_cyc_o        = m_cyc_i[g_q];
                s_stb_o        = m_stb_i[g_q] & ~full;
                m_stall_o[g_q] = s_stall_i | full;
                m_ack_o[g_q]   = s_ack_i;
                m_err_o[g_q]   = s_err_i;
            end
            ABORT: begin
                // Error only on the first abort cycle; later responses are dropped.
                m_err_o[g_q] = timeout_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        last_d    = last_q;
        outst_d   = outst_q;
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                outst_d = '0;
                wdog_d  = '0;
                if (pick_vld) begin
                    g_d     = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!m_cyc_i[g_q]) begin
                    last_d  = g_q;
                    outst_d = '0;
                    wdog_d  = '0;
                    state_d = IDLE;
                end else begin
                    if (accept && !dec)      outst_d = outst_q + CNTW'(1);
                    else if (!accept && dec) outst_d = outst_q - CNTW'(1);
                    // The watchdog restarts on every accept/response and counts the
                    // event cycle itself, so the abort lands TIMEOUT cycles after it.
                    if (outst_d == '0)          wdog_d = '0;
                    else if (accept || resp)    wdog_d = WDW'(1);
                    else                        wdog_d = wdog_q + WDW'(1);
                    if (outst_d != '0 && wdog_d == WDW'(TIMEOUT)) begin
                        state_d   = ABORT;
                        timeout_d = 1'b1;
                        outst_d   = '0;
                        wdog_d    = '0;
                    end
                end
            end
            ABORT: begin
                outst_d = '0;
                wdog_d  = '0;
                if (!m_cyc_i[g_q]) begin
                    last_d  = g_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_d = '0;
        if (state_d != IDLE) gnt_d[g_d] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            g_q       <= '0;
            last_q    <= IDXW'(N_MASTERS - 1);
            outst_q   <= '0;
            wdog_q    <= '0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            last_q    <= last_d;
            outst_q   <= outst_d;
            wdog_q    <= wdog_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic [N-1:0]    m_cyc_i = '0;
    logic [N-1:0]    m_stb_i = '0;
    logic [N-1:0]    m_we_i  = '0;
    logic [N*AW-1:0] m_adr_i = '0;
    logic [N*DW-1:0] m_dat_i = '0;
    logic [N*SW-1:0] m_sel_i = '0;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, m_stall_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat_i = '0;
    logic            s_ack_i = 1'b0, s_err_i = 1'b0, s_stall_i = 1'b0;
    logic [N-1:0]    gnt_o;
    logic            timeout_o;

    int n_chk = 0;
    int n_bad = 0;

    wb_arbiter #(
        .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW),
        .MAX_OUTSTANDING(4), .TIMEOUT(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic cyc, input logic stb,
                        input logic [1:0] stall, input logic [1:0] ack,
                        input logic [1:0] err, input logic [1:0] gnt, input logic to);
        check({tag, "/s_cyc"}, 64'(s_cyc_o), 64'(cyc));
        check({tag, "/s_stb"}, 64'(s_stb_o), 64'(stb));
        check({tag, "/stall"}, 64'(m_stall_o), 64'(stall));
        check({tag, "/ack"}, 64'(m_ack_o), 64'(ack));
        check({tag, "/err"}, 64'(m_err_o), 64'(err));
        check({tag, "/gnt"}, 64'(gnt_o), 64'(gnt));
        check({tag, "/timeout"}, 64'(timeout_o), 64'(to));
    endtask

    task automatic sample(input string tag, input logic cyc, input logic stb,
                          input logic [1:0] stall, input logic [1:0] ack,
                          input logic [1:0] err, input logic [1:0] gnt, input logic to);
        @(negedge clk_i);
        look(tag, cyc, stb, stall, ack, err, gnt, to);
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step(input string tag, input logic cyc, input logic stb,
                        input logic [1:0] stall, input logic [1:0] ack,
                        input logic [1:0] err, input logic [1:0] gnt, input logic to);
        sample(tag, cyc, stb, stall, ack, err, gnt, to);
        adv();
    endtask

    task automatic reset_pulse();
        rst_i = 1'b0;
        adv();
        rst_i = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        look("rst", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        rst_i = 1'b1;

        // Single master 0, three pipelined writes, acks one cycle later
        m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b01;
        m_adr_i[15:0] = 16'h0010; m_dat_i[31:0] = 32'hA5A5_0001; m_sel_i[3:0] = 4'hF;
        m_adr_i[31:16] = 16'h7777; m_dat_i[63:32] = 32'h5555_5555; m_sel_i[7:4] = 4'h3;
        s_dat_i = 32'hDEAD_BEEF;
        step("s1c0", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        sample("s1c1", 1, 1, 2'b10, 2'b00, 2'b00, 2'b01, 0);
        check("s1c1/adr", 64'(s_adr_o), 64'h0010);
        check("s1c1/dat", 64'(s_dat_o), 64'hA5A5_0001);
        check("s1c1/sel", 64'(s_sel_o), 64'hF);
        check("s1c1/we", 64'(s_we_o), 64'h1);
        check("s1c1/rdat", 64'(m_dat_o), 64'hDEAD_BEEF);
        adv();
        m_adr_i[15:0] = 16'h0011; s_ack_i = 1'b1;
        sample("s1c2", 1, 1, 2'b10, 2'b01, 2'b00, 2'b01, 0);
        check("s1c2/adr", 64'(s_adr_o), 64'h0011);
        adv();
        m_adr_i[15:0] = 16'h0012;
        sample("s1c3", 1, 1, 2'b10, 2'b01, 2'b00, 2'b01, 0);
        check("s1c3/adr", 64'(s_adr_o), 64'h0012);
        adv();
        m_stb_i = 2'b00;
        step("s1c4", 1, 0, 2'b10, 2'b01, 2'b00, 2'b01, 0);
        m_cyc_i = 2'b00; s_ack_i = 1'b0;
        step("s1c5", 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0);
        step("s1c6", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);

        // Contention from reset and round-robin order
        reset_pulse();
        m_we_i = 2'b00;
        m_cyc_i = 2'b11;
        step("s2c0", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        step("s2c1", 1, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0);
        m_cyc_i = 2'b10;
        step("s2c2", 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0);
        step("s2c3", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        m_cyc_i = 2'b11;
        sample("s2c4", 1, 0, 2'b01, 2'b00, 2'b00, 2'b10, 0);
        check("s2c4/adr", 64'(s_adr_o), 64'h7777);
        adv();
        m_cyc_i = 2'b01;
        step("s2c5", 0, 0, 2'b01, 2'b00, 2'b00, 2'b10, 0);
        m_cyc_i = 2'b11;
        step("s2c6", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        step("s2c7", 1, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0);
        m_cyc_i = 2'b00;
        step("s2c8", 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0);
        m_cyc_i = 2'b11;
        step("s2c9", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        step("s2c10", 1, 0, 2'b01, 2'b00, 2'b00, 2'b10, 0);
        m_cyc_i = 2'b00;
        step("s2c11", 0, 0, 2'b01, 2'b00, 2'b00, 2'b10, 0);
        step("s2c12", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);

        // Outstanding limit: four accepted, then stall until an ack frees one slot
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        step("s3c0", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        for (int i = 1; i <= 4; i++) step("s3acc", 1, 1, 2'b10, 2'b00, 2'b00, 2'b01, 0);
        step("s3full", 1, 0, 2'b11, 2'b00, 2'b00, 2'b01, 0);
        s_ack_i = 1'b1;
        step("s3ack", 1, 0, 2'b11, 2'b01, 2'b00, 2'b01, 0);
        s_ack_i = 1'b0;
        step("s3one", 1, 1, 2'b10, 2'b00, 2'b00, 2'b01, 0);
        step("s3full2", 1, 0, 2'b11, 2'b00, 2'b00, 2'b01, 0);
        m_cyc_i = 2'b00; m_stb_i = 2'b00;
        step("s3rel", 0, 0, 2'b11, 2'b00, 2'b00, 2'b01, 0);
        step("s3idle", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);

        // Watchdog: master 1 issues one read, slave never answers
        m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b00; m_adr_i[31:16] = 16'h0ABC;
        step("s4c0", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        sample("s4c1", 1, 1, 2'b01, 2'b00, 2'b00, 2'b10, 0);
        check("s4c1/adr", 64'(s_adr_o), 64'h0ABC);
        check("s4c1/we", 64'(s_we_o), 64'h0);
        check("s4c1/sel", 64'(s_sel_o), 64'h3);
        adv();
        m_stb_i = 2'b00;
        for (int i = 2; i <= 8; i++) step("s4wait", 1, 0, 2'b01, 2'b00, 2'b00, 2'b10, 0);
        step("s4abort", 0, 0, 2'b11, 2'b00, 2'b10, 2'b10, 1);
        s_ack_i = 1'b1;
        step("s4drop", 0, 0, 2'b11, 2'b00, 2'b00, 2'b10, 0);
        s_ack_i = 1'b0; m_cyc_i = 2'b00;
        step("s4rel", 0, 0, 2'b11, 2'b00, 2'b00, 2'b10, 0);
        step("s4idle", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);

        // Accept and ack every cycle: one outstanding, never stalled
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        step("s5c0", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        step("s5c1", 1, 1, 2'b10, 2'b00, 2'b00, 2'b01, 0);
        s_ack_i = 1'b1;
        for (int i = 0; i < 10; i++) step("s5flow", 1, 1, 2'b10, 2'b01, 2'b00, 2'b01, 0);
        s_stall_i = 1'b1;
        step("s5stall", 1, 1, 2'b11, 2'b01, 2'b00, 2'b01, 0);
        s_stall_i = 1'b0; s_ack_i = 1'b0; m_stb_i = 2'b00;
        step("s5drain", 1, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0);
        m_cyc_i = 2'b00;
        step("s5rel", 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0);
        step("s5idle", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);

        // Asynchronous reset mid-burst with three outstanding
        m_cyc_i = 2'b10; m_stb_i = 2'b10;
        step("s6c0", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        for (int i = 1; i <= 3; i++) step("s6acc", 1, 1, 2'b01, 2'b00, 2'b00, 2'b10, 0);
        sample("s6c4", 1, 1, 2'b01, 2'b00, 2'b00, 2'b10, 0);
        m_cyc_i = 2'b11;
        #1 rst_i = 1'b0;
        #1 look("s6async", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        adv();
        rst_i = 1'b1;
        step("s6idle", 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
        step("s6prio", 1, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0);
        m_cyc_i = 2'b00; m_stb_i = 2'b00;
        adv();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin arbiter that shares one pipelined Wishbone slave port (the `wb_interface` slave: adr/dat/sel/we/stb/cyc in, dat/ack/err/stall out) between N_MASTERS pipelined masters. It owns bus-cycle grant, routes one master's request signals to the slave, and routes the slave's responses back to that master. It also tracks outstanding transfers so it cannot exceed a depth limit, and aborts hung cycles with a watchdog. It sits between the master drivers and a single slave core.

## Interface
- N_MASTERS, 2: number of requesting masters (2..8).
- ADDR_WIDTH, 16: address width.
- DATA_WIDTH, 32: data width.
- SEL_WIDTH, 4: byte-select width.
- MAX_OUTSTANDING, 4: maximum accepted-but-unacknowledged transfers (1..15).
- TIMEOUT, 255: idle-response cycles before abort (1..65535).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset; asynchronous assert, active-low.
- m_cyc_i  in  N_MASTERS  per-master cycle request.
- m_stb_i  in  N_MASTERS  per-master strobe.
- m_we_i  in  N_MASTERS  per-master write enable.
- m_adr_i  in  N_MASTERS*ADDR_WIDTH  packed addresses; master k occupies slice k.
- m_dat_i  in  N_MASTERS*DATA_WIDTH  packed write data.
- m_sel_i  in  N_MASTERS*SEL_WIDTH  packed byte selects.
- m_dat_o  out  DATA_WIDTH  read data broadcast to all masters (= s_dat_i).
- m_ack_o  out  N_MASTERS  per-master ack.
- m_err_o  out  N_MASTERS  per-master error.
- m_stall_o  out  N_MASTERS  per-master stall.
- s_cyc_o / s_stb_o / s_we_o  out  1 each  to slave.
- s_adr_o  out  ADDR_WIDTH  to slave.
- s_dat_o  out  DATA_WIDTH  to slave.
- s_sel_o  out  SEL_WIDTH  to slave.
- s_dat_i  in  DATA_WIDTH  from slave.
- s_ack_i / s_err_i / s_stall_i  in  1 each  from slave.
- gnt_o  out  N_MASTERS  registered one-hot grant; all zero when idle.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, GRANT, ABORT. Registers: state, grant index g, last-granted pointer, outstanding counter, watchdog counter.
- IDLE:
  - All m_stall_o=1; m_ack_o=m_err_o=0; s_cyc_o=s_stb_o=0.
  - If any m_cyc_i is high, pick the first requester searching from last+1 upward with wrap. Register g and go to GRANT.
- GRANT:
  - s_cyc_o=m_cyc_i[g], s_stb_o=m_stb_i[g]&!full, s_we/adr/dat/sel from slice g (combinational).
  - m_stall_o[g]=s_stall_i|full; all other m_stall_o=1.
  - m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i; others 0.
  - full = (outstanding==MAX_OUTSTANDING).
- Outstanding counter:
  - +1 when s_stb_o&!s_stall_i.
  - −1 when s_ack_i|s_err_i.
  - Both in the same cycle: unchanged.
  - Never decrements below 0; ack/err arriving with outstanding==0 is ignored for counting but still forwarded.
- Release: m_cyc_i[g]=0 in GRANT sets last=g, clears outstanding and watchdog, and goes to IDLE next cycle. Dropping cyc with outstanding>0 is a master protocol violation; the arbiter still releases.
- Watchdog:
  - Counts while in GRANT with outstanding>0 and no s_ack_i/s_err_i.
  - Clears on any ack/err or when outstanding==0.
  - Reaching TIMEOUT moves the state to ABORT.
- ABORT:
  - s_cyc_o=s_stb_o=0; m_stall_o all 1.
  - m_err_o[g]=1 and timeout_o=1 on the first ABORT cycle only.
  - Outstanding is cleared.
  - Stays in ABORT until m_cyc_i[g]=0, then sets last=g and goes to IDLE.
  - Slave responses received during ABORT are dropped.
- Reset (rst_i low, any state, asynchronous):
  - state=IDLE, g=0, last=N_MASTERS-1 so master 0 wins first, counters=0, gnt_o=0.
  - Outputs take their IDLE values immediately: s_cyc_o=s_stb_o=0, m_stall_o all 1, m_ack_o=m_err_o=0, timeout_o=0.
  - An in-flight cycle is abandoned with no err.

## Timing
- Grant latency: m_cyc_i rises in cycle 0 while IDLE → gnt_o and s_cyc_o high in cycle 1. The first transfer can be accepted in cycle 1.
- Handover: m_cyc_i[g] falls in cycle k → s_cyc_o low in cycle k (combinational). IDLE in k+1; the next master's s_cyc_o is high in k+2. There is always at least one cycle of s_cyc_o low between owners.
- Request path and response path are combinational, with zero added latency while in GRANT.
- Simultaneous requests in IDLE are resolved purely by round-robin order.
- Requests arriving during GRANT/ABORT wait; no preemption.
- Abort timing: with TIMEOUT=T, err is asserted exactly T cycles after the last accept/ack event with outstanding>0.

## Test plan
- Single master 0: 3 pipelined writes to 0x0010..0x0012 with slave acking 1 cycle later → s_cyc_o in cycle 1, 3 acks to master 0 only, gnt_o=01 throughout, returns to IDLE after cyc drops.
- Masters 0 and 1 request in the same cycle from reset → 0 granted first. After 0 drops cyc, 1 is granted 2 cycles later. The next contention goes to 0 again only after 1 has been served.
- MAX_OUTSTANDING=4, slave never acks until 6 strobes are offered → exactly 4 accepted, m_stall_o[g]=1 and s_stb_o=0 while full. The first ack unblocks exactly one more transfer.
- TIMEOUT=8, slave accepts 1 read and never responds → in the 8th cycle m_err_o[g]=1 and timeout_o=1 for one cycle, s_cyc_o low. IDLE after the master drops cyc.
- Simultaneous accept and ack each cycle for 10 cycles → outstanding stays at 1 and no stall is asserted.
- rst_i low mid-burst with outstanding=3 → asynchronously s_cyc_o=0 and m_stall_o all 1, gnt_o=0. After release, master 0 has priority.
